// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine change path.
`default_nettype none

package vending_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    SEL      = 3'd2,
    REQ      = 3'd3,
    WAIT_REL = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;

  localparam logic [11:0] COIN_SMALL_VAL = 12'd100;
  localparam logic [11:0] COIN_BIG_VAL   = 12'd500;
  localparam logic [11:0] MAX_VUELTO_VAL = 12'd1500;

  function automatic logic is_multiple(input logic [11:0] value, input logic [11:0] step);
    return (value % step) == 12'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_vuelto.sv
// Change dispenser controller: computes change and pays it as big/small coins over a req/ack ejector.
// Optional ACK_TIMEOUT_EN aborts a transaction when an ack edge does not arrive in time.
`default_nettype none

module controlador_vuelto
  import vending_pkg::*;
#(
  parameter logic [11:0] MAX_VUELTO  = MAX_VUELTO_VAL,
  parameter logic [11:0] COIN_BIG    = COIN_BIG_VAL,
  parameter logic [11:0] COIN_SMALL  = COIN_SMALL_VAL,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] credito,
  input  logic [11:0] precio,
  input  logic        coin_ack,
  output logic        coin_req,
  output logic        coin_sel,
  output logic [11:0] vuelto,
  output logic        disp_en,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t      state;
  logic [11:0] cred_q;
  logic [11:0] prec_q;
  logic [11:0] diff;
  logic [11:0] coin_val;

  assign diff     = cred_q - prec_q;
  assign coin_val = coin_sel ? COIN_BIG : COIN_SMALL;

`ifdef ACK_TIMEOUT_EN
  logic [7:0] ack_cnt;
  logic       ack_expired;
  assign ack_expired = (ack_cnt == ACK_TIMEOUT - 8'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^ACK_TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cred_q   <= '0;
      prec_q   <= '0;
      vuelto   <= '0;
      coin_req <= 1'b0;
      coin_sel <= 1'b0;
      disp_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      ack_cnt  <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      ack_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            cred_q  <= credito;
            prec_q  <= precio;
            busy    <= 1'b1;
            disp_en <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          // diff is only meaningful once the ordering check has passed
          if ((cred_q < prec_q) || (diff > MAX_VUELTO) || !is_multiple(diff, COIN_SMALL)) begin
            error   <= 1'b1;
            disp_en <= 1'b0;
            state   <= ERR;
          end else begin
            vuelto <= diff;
            if (diff == 12'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SEL;
            end
          end
        end
        SEL: begin
          coin_sel <= (vuelto >= COIN_BIG);
          coin_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (coin_ack) begin
            vuelto   <= vuelto - coin_val;
            coin_req <= 1'b0;
            state    <= WAIT_REL;
`ifdef ACK_TIMEOUT_EN
          end else if (ack_expired) begin
            coin_req <= 1'b0;
            error    <= 1'b1;
            disp_en  <= 1'b0;
            state    <= ERR;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
`endif
          end
        end
        WAIT_REL: begin
          if (!coin_ack) begin
            if (vuelto == 12'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SEL;
            end
`ifdef ACK_TIMEOUT_EN
          end else if (ack_expired) begin
            error   <= 1'b1;
            disp_en <= 1'b0;
            state   <= ERR;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/controlador_vuelto.md
# controlador_vuelto

Sequencing controller for the vending machine's change path (Laboratorio 4). It latches credit and price on a start pulse and computes the change. It then dispenses that change as 500 and 100 coins through a request/acknowledge ejector handshake. While it runs, it drives the remaining-change value and enable used by the 4-digit seven-segment change display.

## Interface
- MAX_VUELTO, 1500: largest change the machine may return.
- COIN_BIG, 500: value of the large coin.
- COIN_SMALL, 100: value of the small coin; all amounts must be multiples of it.
- ACK_TIMEOUT, 255: cycles allowed for each ack edge (used only with the timeout feature).
- clk  in  1  single system clock; everything is rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request to begin a transaction.
- credito  in  12  money inserted, unsigned.
- precio  in  12  product price, unsigned.
- coin_ack  in  1  ejector acknowledge (level).
- coin_req  out  1  ejector request (level).
- coin_sel  out  1  coin type: 1 = COIN_BIG, 0 = COIN_SMALL.
- vuelto  out  12  change still owed; feeds the display's amount input.
- disp_en  out  1  display enable.
- busy  out  1  a transaction is in progress.
- done  out  1  one-cycle pulse when the change is fully paid.
- error  out  1  one-cycle pulse when a transaction is rejected or aborted.

## Operation
- States: IDLE, CALC, SEL, REQ, WAIT_REL, DONE, ERR.
- IDLE
  - start=1: latch credito and precio, go to CALC.
  - start while not in IDLE is ignored.
- CALC
  - Reject (go to ERR) if credito<precio, or diff=credito−precio exceeds MAX_VUELTO, or diff is not a multiple of COIN_SMALL.
  - Otherwise load vuelto=diff. If diff==0 go to DONE, else go to SEL.
- SEL
  - Set coin_sel=1 if vuelto≥COIN_BIG, else 0. Go to REQ.
- REQ
  - coin_req=1 and coin_sel held stable.
  - coin_ack sampled 1: subtract the selected coin from vuelto (12-bit, never underflows by construction), drop coin_req, go to WAIT_REL.
- WAIT_REL
  - Wait for coin_ack=0 (four-phase handshake).
  - Then go to DONE if vuelto==0, else go to SEL.
- DONE
  - done=1 for one cycle, then go to IDLE.
- ERR
  - error=1 for one cycle, then go to IDLE.
  - vuelto keeps its value (the unpaid remainder on abort, or the last value after a CALC reject).
- Output behaviour
  - busy=1 in every state except IDLE.
  - disp_en=1 from CALC through DONE, and in IDLE after a successful transaction, until the next start or reset.
  - Coin order is greedy: every COIN_BIG coin is paid before any COIN_SMALL coin.
- Reset
  - All outputs are 0 in reset, including vuelto.
  - Reset mid-handshake abandons the transaction: coin_req drops asynchronously and no coin is accounted.

## Timing
- start in cycle t; CALC runs in t+1.
- First coin_req rises in t+3.
- With ack returned immediately, each coin takes 4 cycles (REQ, ack, WAIT_REL, SEL).
- done is asserted in the cycle after the last ack release is seen.
- The vuelto update is visible in the cycle after coin_ack is sampled high.
- coin_ack already high on entry to REQ counts as the acknowledge.

## Configuration
- ACK_TIMEOUT_EN defined:
  - An 8-bit counter runs in REQ and in WAIT_REL and clears on every state change.
  - When it reaches ACK_TIMEOUT the controller goes to ERR and coin_req drops.
- ACK_TIMEOUT_EN undefined:
  - No counter; the controller waits indefinitely for each handshake edge.

## Structure
- Package vending_pkg holds:
  - the state enum;
  - the coin constants (100, 500);
  - the MAX_VUELTO constant.
- Sub-module: the existing change display decoder, instantiated at top level on vuelto/disp_en, not inside this block.
- The controller itself is a single module with no sub-modules.

## Test plan
- credito=1500, precio=700 -> vuelto=800; coins 500, 100, 100, 100; vuelto steps 300, 200, 100, 0; done pulse; error never asserted.
- credito=600, precio=600 -> done 2 cycles after start; no coin_req.
- credito=300, precio=500 -> error pulse in the cycle after CALC; vuelto=0; coin_req never asserted.
- credito=2000, precio=100 (change 1900) -> error pulse; no coin_req. Separately, credito=1250 with precio=200 (not a multiple of 100) -> error pulse.
- ack withheld with ACK_TIMEOUT_EN defined -> error after 255 cycles in REQ; vuelto holds the remainder. Undefined -> still busy after 1000 cycles.
- rst_n low while in WAIT_REL -> all outputs 0 immediately; the next start runs a clean transaction.
